l1_l2_port_arbiter: RTL and testbench

- Clocked arbiter sharing the single L1->L2 transfer port between the L1 instruction cache (requester I) and the L1 data cache (requester D).
- Sits between both L1 cache uc-side ports and the L1/L2 txrx buffer.
- Grants one requester per block transaction, holds the grant until every word of the block has moved, then re-arbitrates.
- Fixed priority to I, with an aging counter that guarantees D forward progress.

---
 rtl/l1_arb_pkg.sv | 25 ++
 rtl/l1_arb_beat_counter.sv | 45 ++++
 rtl/l1_l2_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_l1_l2_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// Shared definitions for the L1->L2 port arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - GNT_*       : one-hot grant codes driven on grant_o
//   - state_grant : maps an FSM state to its grant code
package l1_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  function automatic logic [1:0] state_grant(input arb_state_e st);
    case (st)
      GRANT_I: state_grant = GNT_I;
      GRANT_D: state_grant = GNT_D;
      default: state_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/l1_arb_beat_counter.sv
// Block-word counter for one granted transaction.
//   clock_i, reset_i : clock, asynchronous active-low reset
//   clear_i          : hold the counter at zero (no transaction active)
//   beat_i           : one word completed this cycle
//   count_o          : words completed so far in the current block
//   done_o           : this beat is the last word of the block
module l1_arb_beat_counter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           clear_i,
  input  logic                           beat_i,
  output logic [$clog2(BLOCK_WORDS):0]   count_o,
  output logic                           done_o
);

  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  logic [CW-1:0] count_q, count_d;

  assign done_o  = beat_i && (count_q == LAST);
  assign count_o = count_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear_i || done_o) begin
      count_d = '0;
    end else if (beat_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/l1_l2_port_arbiter.sv
// Arbiter sharing the single L1->L2 transfer port between the L1 I-cache
// (requester I) and the L1 D-cache (requester D).
//   clock_i, reset_i      : clock, asynchronous active-low reset
//   l1i_* / l1d_* inputs  : block request, direction, address, write data, word strobes
//   l1i_* / l1d_* outputs : buffer handshakes and read data, live for the granted side only
//   buf_*                 : muxed port towards the L1/L2 txrx buffer
//   grant_o               : one-hot grant ([0] = I, [1] = D), busy_o = grant active
// Fixed priority to I; after MAX_WAIT consecutive I grants lost by D, D is forced.
module l1_l2_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int MAX_WAIT    = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        l1i_req_i,
  input  logic        l1d_req_i,
  input  logic        l1i_rw_i,
  input  logic        l1d_rw_i,
  input  logic [23:0] l1i_add_i,
  input  logic [23:0] l1d_add_i,
  input  logic [31:0] l1i_data_i,
  input  logic [31:0] l1d_data_i,
  input  logic        l1i_write_i,
  input  logic        l1d_write_i,
  input  logic        l1i_read_i,
  input  logic        l1d_read_i,
  output logic        l1i_ready_read_o,
  output logic        l1d_ready_read_o,
  output logic        l1i_ready_write_o,
  output logic        l1d_ready_write_o,
  output logic [31:0] l1i_data_o,
  output logic [31:0] l1d_data_o,
  output logic        buf_req_o,
  output logic        buf_rw_o,
  output logic [23:0] buf_add_o,
  output logic [31:0] buf_data_o,
  output logic        buf_write_o,
  output logic        buf_read_o,
  input  logic        buf_ready_read_i,
  input  logic        buf_ready_write_i,
  input  logic [31:0] buf_data_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  wait_q, wait_d;

  logic        gnt_i, gnt_d;
  logic        sel_req, sel_rw, sel_write, sel_read;
  logic        beat, done, early_rel;
  logic [$clog2(BLOCK_WORDS):0] beat_count;

  assign gnt_i = grant_q[0];
  assign gnt_d = grant_q[1];

  // Granted requester's controls; all zero when idle so no beat can be seen.
  always_comb begin
    sel_req    = 1'b0;
    sel_rw     = 1'b0;
    sel_write  = 1'b0;
    sel_read   = 1'b0;
    buf_add_o  = '0;
    buf_data_o = '0;
    if (gnt_i) begin
      sel_req    = l1i_req_i;
      sel_rw     = l1i_rw_i;
      sel_write  = l1i_write_i;
      sel_read   = l1i_read_i;
      buf_add_o  = l1i_add_i;
      buf_data_o = l1i_data_i;
    end else if (gnt_d) begin
      sel_req    = l1d_req_i;
      sel_rw     = l1d_rw_i;
      sel_write  = l1d_write_i;
      sel_read   = l1d_read_i;
      buf_add_o  = l1d_add_i;
      buf_data_o = l1d_data_i;
    end
  end

  assign buf_req_o   = sel_req;
  assign buf_rw_o    = sel_rw;
  assign buf_write_o = sel_write;
  assign buf_read_o  = sel_read;

  assign l1i_ready_read_o  = gnt_i & buf_ready_read_i;
  assign l1i_ready_write_o = gnt_i & buf_ready_write_i;
  assign l1i_data_o        = gnt_i ? buf_data_i : '0;
  assign l1d_ready_read_o  = gnt_d & buf_ready_read_i;
  assign l1d_ready_write_o = gnt_d & buf_ready_write_i;
  assign l1d_data_o        = gnt_d ? buf_data_i : '0;

  assign grant_o = grant_q;
  assign busy_o  = |grant_q;

  assign beat = sel_rw ? (buf_ready_write_i & sel_write) : (buf_ready_read_i & sel_read);

  // A requester may withdraw only before its first word; once words move the block must finish.
  assign early_rel = (state_q != IDLE) && !sel_req && (beat_count == '0) && !beat;

  l1_arb_beat_counter #(
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_beat_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (state_q == IDLE),
    .beat_i  (beat),
    .count_o (beat_count),
    .done_o  (done)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (l1d_req_i && (!l1i_req_i || wait_q == WAIT_MAX)) begin
          state_d = GRANT_D;
          wait_d  = '0;
        end else if (l1i_req_i) begin
          state_d = GRANT_I;
          // D lost this round; age it, saturating so it never wraps.
          if (l1d_req_i && wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (done || early_rel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = state_grant(state_d);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
module tb_l1_l2_port_arbiter;

  localparam int BW = 8;
  localparam int MW = 4;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_I    = 2'b01;
  localparam logic [1:0] G_D    = 2'b10;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        l1i_req_i, l1d_req_i, l1i_rw_i, l1d_rw_i;
  logic [23:0] l1i_add_i, l1d_add_i;
  logic [31:0] l1i_data_i, l1d_data_i;
  logic        l1i_write_i, l1d_write_i, l1i_read_i, l1d_read_i;
  logic        l1i_ready_read_o, l1d_ready_read_o, l1i_ready_write_o, l1d_ready_write_o;
  logic [31:0] l1i_data_o, l1d_data_o;
  logic        buf_req_o, buf_rw_o, buf_write_o, buf_read_o;
  logic [23:0] buf_add_o;
  logic [31:0] buf_data_o;
  logic        buf_ready_read_i, buf_ready_write_i;
  logic [31:0] buf_data_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  l1_l2_port_arbiter #(.BLOCK_WORDS(BW), .MAX_WAIT(MW)) dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .l1i_req_i         (l1i_req_i),
    .l1d_req_i         (l1d_req_i),
    .l1i_rw_i          (l1i_rw_i),
    .l1d_rw_i          (l1d_rw_i),
    .l1i_add_i         (l1i_add_i),
    .l1d_add_i         (l1d_add_i),
    .l1i_data_i        (l1i_data_i),
    .l1d_data_i        (l1d_data_i),
    .l1i_write_i       (l1i_write_i),
    .l1d_write_i       (l1d_write_i),
    .l1i_read_i        (l1i_read_i),
    .l1d_read_i        (l1d_read_i),
    .l1i_ready_read_o  (l1i_ready_read_o),
    .l1d_ready_read_o  (l1d_ready_read_o),
    .l1i_ready_write_o (l1i_ready_write_o),
    .l1d_ready_write_o (l1d_ready_write_o),
    .l1i_data_o        (l1i_data_o),
    .l1d_data_o        (l1d_data_o),
    .buf_req_o         (buf_req_o),
    .buf_rw_o          (buf_rw_o),
    .buf_add_o         (buf_add_o),
    .buf_data_o        (buf_data_o),
    .buf_write_o       (buf_write_o),
    .buf_read_o        (buf_read_o),
    .buf_ready_read_i  (buf_ready_read_i),
    .buf_ready_write_i (buf_ready_write_i),
    .buf_data_i        (buf_data_i),
    .grant_o           (grant_o),
    .busy_o            (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    bit          side;  // 0 = I, 1 = D
    logic [31:0] data;
  } beat_t;

  beat_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input bit side, input logic [31:0] got);
    beat_t e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_beat", 32'(side), 32'hFFFF_FFFF);
      return;
    end
    e = sb_q.pop_front();
    check("sb_side", 32'(side), 32'(e.side));
    check("sb_data", got, e.data);
  endtask

  // Scoreboard consumer: every completed word on the DUT side pops one expectation.
  always @(negedge clock_i) begin
    if (l1i_ready_read_o && l1i_read_i) sb_pop(1'b0, l1i_data_o);
    if (l1d_ready_read_o && l1d_read_i) sb_pop(1'b1, l1d_data_o);
    if (buf_write_o && buf_ready_write_i) sb_pop(grant_o[1], buf_data_o);
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_beat_inputs();
    buf_ready_read_i  = 1'b0;
    buf_ready_write_i = 1'b0;
    l1i_read_i        = 1'b0;
    l1d_read_i        = 1'b0;
    l1i_write_i       = 1'b0;
    l1d_write_i       = 1'b0;
  endtask

  // Drives n accepted words for the granted side; both sides strobe so the
  // loser's strobes must be ignored. Checks grant hold and loser gating per cycle.
  task automatic run_block(input bit side, input bit rw, input int n, input bit toggle,
                           input logic [31:0] base, input logic [1:0] gnt);
    int    k   = 0;
    int    cyc = 0;
    beat_t e;
    logic [31:0] w;
    while (k < n && cyc < 4 * n) begin
      check("hold_grant", 32'(grant_o), 32'(gnt));
      w = base + 32'(k);
      if (!rw) begin
        buf_ready_read_i = 1'b1;
        buf_data_i       = w;
        l1i_read_i       = 1'b1;
        l1d_read_i       = 1'b1;
        e.side = side; e.data = w;
        sb_q.push_back(e);
        k++;
      end else begin
        buf_ready_write_i = toggle ? (cyc % 2 == 0) : 1'b1;
        l1i_write_i = 1'b1;
        l1d_write_i = 1'b1;
        l1i_data_i  = side ? ~w : w;
        l1d_data_i  = side ? w : ~w;
        if (buf_ready_write_i) begin
          e.side = side; e.data = w;
          sb_q.push_back(e);
          k++;
        end
      end
      #1;
      if (side) begin
        check("loser_i_rd", 32'(l1i_ready_read_o), 32'd0);
        check("loser_i_wr", 32'(l1i_ready_write_o), 32'd0);
        check("loser_i_data", l1i_data_o, 32'd0);
      end else begin
        check("loser_d_rd", 32'(l1d_ready_read_o), 32'd0);
        check("loser_d_wr", 32'(l1d_ready_write_o), 32'd0);
        check("loser_d_data", l1d_data_o, 32'd0);
      end
      tick();
      cyc++;
    end
    if (k < n) check("beat_budget", 32'(k), 32'(n));
    clear_beat_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    l1i_req_i = 1'b1; l1d_req_i = 1'b0; l1i_rw_i = 1'b0; l1d_rw_i = 1'b0;
    l1i_add_i = 24'h0; l1d_add_i = 24'h0; l1i_data_i = 32'h0; l1d_data_i = 32'h0;
    clear_beat_inputs();
    buf_ready_read_i = 1'b1;
    buf_data_i = 32'hA5A5_0000;

    // Reset: outputs must be quiet even with a request and buffer activity present.
    #12;
    check("rst_grant", 32'(grant_o), 32'(G_NONE));
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_buf_req", 32'(buf_req_o), 32'd0);
    check("rst_i_ready", 32'(l1i_ready_read_o), 32'd0);
    check("rst_i_data", l1i_data_o, 32'd0);
    l1i_req_i = 1'b0;
    clear_beat_inputs();
    tick();
    reset_i = 1'b1;
    tick();

    // 1: I read alone, 1-cycle arbitration latency, release after beat 8.
    l1i_req_i = 1'b1; l1i_rw_i = 1'b0; l1i_add_i = 24'h001000;
    #1;
    check("t1_no_grant_yet", 32'(grant_o), 32'(G_NONE));
    tick();
    check("t1_grant", 32'(grant_o), 32'(G_I));
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_buf_req", 32'(buf_req_o), 32'd1);
    check("t1_buf_add", 32'(buf_add_o), 32'h001000);
    run_block(1'b0, 1'b0, BW, 1'b0, 32'h100, G_I);
    check("t1_release", 32'(grant_o), 32'(G_NONE));
    check("t1_not_busy", 32'(busy_o), 32'd0);
    l1i_req_i = 1'b0;
    tick();
    check("t1_stay_idle", 32'(grant_o), 32'(G_NONE));

    // 2: simultaneous requests, I first, D after one idle cycle.
    l1i_req_i = 1'b1; l1d_req_i = 1'b1; l1d_rw_i = 1'b0;
    l1i_add_i = 24'h001100; l1d_add_i = 24'h002000;
    tick();
    check("t2_i_first", 32'(grant_o), 32'(G_I));
    check("t2_i_add", 32'(buf_add_o), 32'h001100);
    run_block(1'b0, 1'b0, BW, 1'b0, 32'h200, G_I);
    check("t2_idle_gap", 32'(grant_o), 32'(G_NONE));
    l1i_req_i = 1'b0;
    tick();
    check("t2_d_next", 32'(grant_o), 32'(G_D));
    check("t2_d_add", 32'(buf_add_o), 32'h002000);
    run_block(1'b1, 1'b0, BW, 1'b0, 32'h300, G_D);
    check("t2_d_release", 32'(grant_o), 32'(G_NONE));
    l1d_req_i = 1'b0;
    tick();

    // 3: aging — D loses MAX_WAIT times, then is forced; wait counter clears.
    l1i_req_i = 1'b1; l1d_req_i = 1'b1;
    for (int g = 0; g < MW; g++) begin
      tick();
      check("t3_i_grant", 32'(grant_o), 32'(G_I));
      run_block(1'b0, 1'b0, BW, 1'b0, 32'h1000 + 32'(g * 16), G_I);
      check("t3_gap", 32'(grant_o), 32'(G_NONE));
    end
    tick();
    check("t3_d_forced", 32'(grant_o), 32'(G_D));
    run_block(1'b1, 1'b0, BW, 1'b0, 32'h2000, G_D);
    check("t3_d_release", 32'(grant_o), 32'(G_NONE));
    tick();
    check("t3_wait_cleared", 32'(grant_o), 32'(G_I));
    run_block(1'b0, 1'b0, BW, 1'b0, 32'h3000, G_I);
    check("t3_i_release", 32'(grant_o), 32'(G_NONE));
    l1i_req_i = 1'b0; l1d_req_i = 1'b0;
    tick();

    // 4: D write block with buffer ready toggling.
    l1d_req_i = 1'b1; l1d_rw_i = 1'b1; l1d_add_i = 24'h004000;
    tick();
    check("t4_d_grant", 32'(grant_o), 32'(G_D));
    check("t4_rw", 32'(buf_rw_o), 32'd1);
    run_block(1'b1, 1'b1, BW, 1'b1, 32'h400, G_D);
    check("t4_release", 32'(grant_o), 32'(G_NONE));
    l1d_req_i = 1'b0; l1d_rw_i = 1'b0;
    tick();

    // 5: early release by I, pending D granted the cycle after.
    l1i_req_i = 1'b1; l1i_rw_i = 1'b0;
    tick();
    check("t5_i_grant", 32'(grant_o), 32'(G_I));
    l1i_req_i = 1'b0; l1d_req_i = 1'b1; l1d_rw_i = 1'b0;
    tick();
    check("t5_early_release", 32'(grant_o), 32'(G_NONE));
    tick();
    check("t5_d_grant", 32'(grant_o), 32'(G_D));
    run_block(1'b1, 1'b0, BW, 1'b0, 32'h500, G_D);
    check("t5_release", 32'(grant_o), 32'(G_NONE));
    l1d_req_i = 1'b0;
    tick();

    // 6: asynchronous reset at beat 3 of a D read.
    l1d_req_i = 1'b1; l1d_rw_i = 1'b0;
    tick();
    check("t6_d_grant", 32'(grant_o), 32'(G_D));
    run_block(1'b1, 1'b0, 2, 1'b0, 32'h600, G_D);
    check("t6_mid_block", 32'(grant_o), 32'(G_D));
    buf_ready_read_i = 1'b1; buf_data_i = 32'h602; l1d_read_i = 1'b1;
    #1;
    check("t6_beat3_live", 32'(l1d_ready_read_o), 32'd1);
    #1;
    reset_i = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant_o), 32'(G_NONE));
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_ready", 32'(l1d_ready_read_o), 32'd0);
    check("t6_rst_data", l1d_data_o, 32'd0);
    check("t6_rst_buf_req", 32'(buf_req_o), 32'd0);
    tick();
    check("t6_rst_hold", 32'(grant_o), 32'(G_NONE));
    clear_beat_inputs();
    l1d_req_i = 1'b0;
    reset_i = 1'b1;
    tick();
    l1i_req_i = 1'b1; l1i_rw_i = 1'b0;
    tick();
    check("t6_i_grant", 32'(grant_o), 32'(G_I));
    run_block(1'b0, 1'b0, BW, 1'b0, 32'h700, G_I);
    check("t6_full_block", 32'(grant_o), 32'(G_NONE));
    l1i_req_i = 1'b0;
    tick();
    tick();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
